// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with hold/shift-right/shift-left/load and a saturating shift counter
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           pin,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qbar,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0] cnt_nxt;
  logic shift;
  // next word and counter; only the serial/parallel input of the active mode is consulted
  always_comb begin
    shift = mode[0] ^ mode[1];
    q_nxt = mode == 2'b01 ? {sin_r, q[WIDTH-1:1]} :
            mode == 2'b10 ? {q[WIDTH-2:0], sin_l} :
            mode == 2'b11 ? pin : q;
    cnt_nxt = mode == 2'b11 ? '0 : (shift && !done) ? cnt + 1'b1 : cnt;
  end
  // state register: reset beats enable, enable gates every update
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RESET_VAL;
      cnt <= '0;
    end else if (en) begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end
  assign qbar   = ~q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  assign done   = cnt == FULL;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg at WIDTH=8 and WIDTH=2
module tb_univ_shift_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, sin_r, sin_l;
  logic [1:0] mode;
  logic [7:0] pin, q, qbar;
  logic       sout_r, sout_l, done;
  logic [3:0] cnt;

  logic       rst2, en2, sin_r2, sin_l2;
  logic [1:0] mode2;
  logic [1:0] pin2, q2, qbar2;
  logic       sout_r2, sout_l2, done2;
  logic [1:0] cnt2;

  int checks = 0;
  int failures = 0;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
    .q(q), .qbar(qbar), .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
  );

  univ_shift_reg #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .sin_r(sin_r2), .sin_l(sin_l2), .pin(pin2),
    .q(q2), .qbar(qbar2), .sout_r(sout_r2), .sout_l(sout_l2), .cnt(cnt2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step8(input logic r, input logic e, input logic [1:0] m,
                       input logic sr, input logic sl, input logic [7:0] p);
    rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic r, input logic e, input logic [1:0] m,
                       input logic sr, input logic sl, input logic [1:0] p);
    rst2 = r; en2 = e; mode2 = m; sin_r2 = sr; sin_l2 = sl; pin2 = p;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] piso;
    logic [7:0] sipo;
    rst = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pin = 8'h00;
    rst2 = 1'b0; en2 = 1'b0; mode2 = 2'b00; sin_r2 = 1'b0; sin_l2 = 1'b0; pin2 = 2'b00;
    // reset for two edges, then release with en=0
    step8(1, 0, 2'b00, 0, 0, 8'h00);
    step8(1, 0, 2'b00, 0, 0, 8'h00);
    rst = 1'b0;
    chk("rst_q", q, 8'hA5);
    chk("rst_qbar", qbar, 8'h5A);
    chk("rst_cnt", cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_sout_r", sout_r, 1);
    chk("rst_sout_l", sout_l, 1);
    for (int i = 0; i < 4; i++) begin
      step8(0, 0, 2'b11, 1, 1, 8'hFF);
      chk("en0_hold_q", q, 8'hA5);
      chk("en0_hold_cnt", cnt, 0);
    end
    // PISO: load B4 then shift right 8 times with sin_r=0
    step8(0, 1, 2'b11, 1, 1, 8'hB4);
    chk("load_q", q, 8'hB4);
    chk("load_cnt", cnt, 0);
    piso = 8'hB4;
    for (int i = 0; i < 8; i++) begin
      chk("piso_sout_r", sout_r, piso[i]);
      chk("piso_cnt", cnt, i);
      chk("piso_done", done, 0);
      step8(0, 1, 2'b01, 0, 1, 8'hFF);
    end
    chk("piso_q", q, 8'h00);
    chk("piso_cnt_full", cnt, 8);
    chk("piso_done_full", done, 1);
    // SIPO from reset
    step8(1, 0, 2'b00, 0, 0, 8'h00);
    chk("sipo_rst_q", q, 8'hA5);
    sipo = 8'b1011_0011;
    for (int i = 7; i >= 0; i--) begin
      step8(0, 1, 2'b10, 1, sipo[i], 8'h00);
      chk("sipo_done", done, i == 0);
    end
    chk("sipo_q", q, 8'hB3);
    chk("sipo_sout_l", sout_l, 1);
    chk("sipo_cnt", cnt, 8);
    step8(0, 1, 2'b10, 1, 0, 8'h00);
    chk("sat_q", q, 8'h66);
    chk("sat_cnt", cnt, 8);
    chk("sat_done", done, 1);
    // enable/hold gating interleaved with shift right
    step8(0, 1, 2'b11, 0, 0, 8'hC3);
    chk("reload_q", q, 8'hC3);
    chk("reload_cnt", cnt, 0);
    chk("reload_done", done, 0);
    step8(0, 1, 2'b01, 1, 0, 8'h00);
    chk("gate_s1_q", q, 8'hE1);
    step8(0, 0, 2'b01, 0, 0, 8'h00);
    chk("gate_en0_q", q, 8'hE1);
    chk("gate_en0_cnt", cnt, 1);
    step8(0, 1, 2'b00, 0, 1, 8'hFF);
    chk("gate_hold_q", q, 8'hE1);
    chk("gate_hold_cnt", cnt, 1);
    step8(0, 1, 2'b01, 0, 1, 8'hFF);
    chk("gate_s2_q", q, 8'h70);
    step8(0, 0, 2'b11, 1, 1, 8'hFF);
    chk("gate_en0b_q", q, 8'h70);
    step8(0, 1, 2'b01, 1, 0, 8'h00);
    chk("gate_s3_q", q, 8'hB8);
    chk("gate_s3_cnt", cnt, 3);
    // mid-operation reset with en=1, mode=01
    step8(1, 1, 2'b01, 1, 1, 8'hFF);
    chk("midrst_q", q, 8'hA5);
    chk("midrst_cnt", cnt, 0);
    step8(0, 1, 2'b11, 0, 0, 8'h0F);
    chk("after_rst_q", q, 8'h0F);
    chk("after_rst_qbar", qbar, 8'hF0);
    step8(0, 0, 2'b00, 0, 0, 8'h00);
    // WIDTH=2: mixed direction
    step2(1, 0, 2'b00, 0, 0, 2'b00);
    chk("w2_rst_q", q2, 2'b00);
    chk("w2_rst_qbar", qbar2, 2'b11);
    step2(0, 1, 2'b11, 0, 0, 2'b10);
    chk("w2_load_q", q2, 2'b10);
    chk("w2_load_sout_r", sout_r2, 0);
    step2(0, 1, 2'b01, 1, 0, 2'b00);
    chk("w2_sr_q", q2, 2'b11);
    chk("w2_sr_cnt", cnt2, 1);
    chk("w2_sr_done", done2, 0);
    step2(0, 1, 2'b10, 0, 0, 2'b00);
    chk("w2_sl_q", q2, 2'b10);
    chk("w2_sl_cnt", cnt2, 2);
    chk("w2_sl_done", done2, 1);
    chk("w2_sout_l", sout_l2, 1);
    step2(0, 1, 2'b01, 0, 0, 2'b00);
    chk("w2_sat_cnt", cnt2, 2);
    chk("w2_sat_q", q2, 2'b01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with four modes: hold, shift right, shift left and parallel load. It has serial ports at both ends, parallel in/out, complementary outputs, and a saturating shift counter that flags when a full word has been shifted since the last load. It generalises the single-bit SISO stage to SISO/SIPO/PISO/PIPO use at any width. It sits between serial links and parallel datapaths.

## Interface
- WIDTH, 8, register width in bits; legal values are 2 and above.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  2  operating mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input for shift right; enters at the MSB.
- sin_l  input  1  serial input for shift left; enters at the LSB.
- pin  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- qbar  output  WIDTH  bitwise complement of q.
- sout_r  output  1  serial output for shift right; equals q[0].
- sout_l  output  1  serial output for shift left; equals q[WIDTH-1].
- cnt  output  $clog2(WIDTH+1)  number of shifts since the last load or reset; saturates at WIDTH.
- done  output  1  high while cnt == WIDTH.

## Operation
- Priority at each rising edge: rst, then en, then mode.
- rst=1: q=RESET_VAL, cnt=0. This applies regardless of en, mode or any in-flight shift.
- en=0: q and cnt hold.
- mode 00 (hold): q and cnt hold.
- mode 01 (shift right): q <= {sin_r, q[WIDTH-1:1]}. cnt <= cnt+1 if cnt<WIDTH, otherwise it holds.
- mode 10 (shift left): q <= {q[WIDTH-2:0], sin_l}. cnt increments and saturates exactly as in shift right.
- mode 11 (parallel load): q <= pin, cnt <= 0.
- Direction changes mid-word do not reset cnt; cnt counts shifts in either direction.
- done is a level, not a pulse. It stays high while cnt sits at WIDTH and clears only on load or reset.
- Outputs that are combinational from registers: qbar=~q, sout_r=q[0], sout_l=q[WIDTH-1], done=(cnt==WIDTH).
- No X propagation from unused inputs: sin_r is ignored outside mode 01, sin_l outside mode 10, pin outside mode 11.

## Timing
- All register updates take one cycle. A change on q is visible in the cycle after the qualifying edge.
- Serial latency:
  - A bit presented on sin_r reaches sout_r after WIDTH shift-right edges.
  - A bit on sin_l reaches sout_l after WIDTH shift-left edges.
- Parallel latency: pin appears on q one edge after a load.
- Parallel-to-serial: the first serial bit is on sout_r/sout_l immediately after the load edge. The remaining WIDTH-1 bits follow, one per shift edge.
- done rises on the edge that performs the WIDTH-th shift and remains high until a load or reset.
- Reset values:
  - q=RESET_VAL, qbar=~RESET_VAL.
  - sout_r=RESET_VAL[0], sout_l=RESET_VAL[WIDTH-1].
  - cnt=0, done=0.
- Simultaneous rst and en with any mode: reset wins, and the counter does not advance.

## Test plan
- Reset check (WIDTH=8, RESET_VAL=8'hA5): hold rst=1 for 2 edges, then release with en=0 → q=8'hA5, qbar=8'h5A, cnt=0, done=0, all holding for 4 edges.
- Parallel load then shift right (PISO): load pin=8'hB4, then 8 edges of mode 01 with sin_r=0.
  - sout_r must read 0,0,1,0,1,1,0,1 (LSB first).
  - Afterwards q=8'h00, cnt=8, done=1.
- Shift left (SIPO): from reset, apply 8 edges of mode 10 with sin_l=1,0,1,1,0,0,1,1 → q=8'hB3, done=1 on the 8th edge.
  - A 9th shift keeps cnt=8.
- Enable and hold gating: during a shift-right sequence, interleave en=0 and mode 00 cycles → q and cnt are unchanged on those edges. The final word still matches the reference model.
- Mid-operation reset: after 3 shifts (cnt=3), assert rst for one edge with mode 01 and en=1 → q=RESET_VAL, cnt=0 on that edge. The next load of 8'h0F gives q=8'h0F.
- Mixed direction and minimum width (WIDTH=2): load 2'b10, shift right with sin_r=1 → q=2'b11. Then shift left with sin_l=0 → q=2'b10, cnt=2, done=1.
